// File: rtl/pfpu32_cmp_pkg.sv
// Shared types, constants and operand unpacking for the FP compare controller.
// Provides the FSM state enum, the unpacked-operand struct and unpack_op().
`ifndef OR1K_FPUOP_WIDTH
`define OR1K_FPUOP_WIDTH 8
`endif
`ifndef OR1K_FPUOP_GENERIC_CMP_SELECT
`define OR1K_FPUOP_GENERIC_CMP_SELECT 2:0
`endif

package pfpu32_cmp_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_UNPACK,
        S_CMP,
        S_DONE
    } state_t;

    typedef struct packed {
        logic        sign;
        logic [9:0]  exp10;
        logic [23:0] fract24;
        logic        snan;
        logic        qnan;
        logic        inf;
        logic        zero;
    } unpacked_t;

    localparam logic [7:0] EXP8_ALL1 = 8'hFF;
    localparam int         QNAN_BIT  = 22;

    localparam logic [2:0] CMP_EQ = 3'd0;
    localparam logic [2:0] CMP_NE = 3'd1;
    localparam logic [2:0] CMP_GT = 3'd2;
    localparam logic [2:0] CMP_GE = 3'd3;
    localparam logic [2:0] CMP_LT = 3'd4;
    localparam logic [2:0] CMP_LE = 3'd5;

    // Denormals keep exp10 = 1 with a zero hidden bit, so magnitude
    // order across the normal/denormal boundary is preserved.
    function automatic unpacked_t unpack_op(
        input logic [31:0] raw,
        input logic        daz
    );
        unpacked_t   u;
        logic [7:0]  e;
        logic [22:0] m;
        e         = raw[30:23];
        m         = raw[22:0];
        u.sign    = raw[31];
        u.exp10   = (e == 8'h00) ? 10'd1 : {2'b00, e};
        u.fract24 = {e != 8'h00, m};
        u.zero    = (e == 8'h00) && (daz || (m == 23'd0));
        u.inf     = (e == EXP8_ALL1) && (m == 23'd0);
        u.qnan    = (e == EXP8_ALL1) && m[QNAN_BIT];
        u.snan    = (e == EXP8_ALL1) && !m[QNAN_BIT] && (m != 23'd0);
        return u;
    endfunction

endpackage

// File: rtl/pfpu32_cmp_ctrl_fcmp.sv
// pfpu32_fcmp: single-precision comparator on unpacked operands.
// Ports: compare type/unordered select, per-operand fields; flag, inv, inf out.
module pfpu32_fcmp
    import pfpu32_cmp_pkg::*;
(
    input  logic        fpu_op_is_comp_i,
    input  logic [2:0]  cmp_type_i,
    input  logic        unordered_i,
    input  logic        signa_i,
    input  logic [9:0]  exp10a_i,
    input  logic [23:0] fract24a_i,
    input  logic        snan_a_i,
    input  logic        qnan_a_i,
    input  logic        inf_a_i,
    input  logic        zero_a_i,
    input  logic        signb_i,
    input  logic [9:0]  exp10b_i,
    input  logic [23:0] fract24b_i,
    input  logic        snan_b_i,
    input  logic        qnan_b_i,
    input  logic        inf_b_i,
    input  logic        zero_b_i,
    output logic        cmp_flag_o,
    output logic        addsub_agtb_o,
    output logic        addsub_aeqb_o,
    output logic        inv_o,
    output logic        inf_o
);

    logic [33:0] mag_a;
    logic [33:0] mag_b;
    logic        agtb;
    logic        aeqb;
    logic        any_snan;
    logic        any_qnan;
    logic        any_nan;
    logic        both_zero;
    logic        eq;
    logic        gt;
    logic        lt;
    logic        rel;
    logic        ord_flag;
    logic        valid_type;

    // Zero flag overrides the fraction so DAZ-flushed denormals
    // compare as zero.
    assign mag_a = zero_a_i ? 34'd0 : {exp10a_i, fract24a_i};
    assign mag_b = zero_b_i ? 34'd0 : {exp10b_i, fract24b_i};
    assign agtb  = mag_a > mag_b;
    assign aeqb  = mag_a == mag_b;

    assign any_snan  = snan_a_i | snan_b_i;
    assign any_qnan  = qnan_a_i | qnan_b_i;
    assign any_nan   = any_snan | any_qnan;
    assign both_zero = zero_a_i & zero_b_i;

    assign eq = both_zero | (aeqb & (signa_i == signb_i));
    assign gt = both_zero         ? 1'b0 :
                signa_i != signb_i ? !signa_i :
                signa_i            ? (!agtb & !aeqb) : agtb;
    assign lt = !gt & !eq;

    assign rel = (cmp_type_i == CMP_GT) | (cmp_type_i == CMP_GE) |
                 (cmp_type_i == CMP_LT) | (cmp_type_i == CMP_LE);
    assign valid_type = cmp_type_i <= CMP_LE;

    always_comb begin
        ord_flag = 1'b0;
        case (cmp_type_i)
            CMP_EQ:  ord_flag = eq;
            CMP_NE:  ord_flag = !eq;
            CMP_GT:  ord_flag = gt;
            CMP_GE:  ord_flag = gt | eq;
            CMP_LT:  ord_flag = lt;
            CMP_LE:  ord_flag = lt | eq;
            default: ord_flag = 1'b0;
        endcase
    end

    // A NaN makes every ordered relation false except "not equal".
    assign cmp_flag_o = fpu_op_is_comp_i &
        (any_nan ? (valid_type & (unordered_i | (cmp_type_i == CMP_NE)))
                 : ord_flag);
    assign inv_o = fpu_op_is_comp_i &
        (any_snan | (any_qnan & rel & !unordered_i));
    assign inf_o = fpu_op_is_comp_i & (inf_a_i | inf_b_i);

    assign addsub_agtb_o = agtb;
    assign addsub_aeqb_o = aeqb;

endmodule

// File: rtl/pfpu32_cmp_ctrl.sv
// pfpu32_cmp_ctrl: sequencing controller for the single-precision compare.
// Ports: clk/rst, flush_i, start_i/ready_o request handshake with opc_i,
// unordered_i, rfa_i, rfb_i; valid_o/ack_i result handshake with flag_o,
// inv_o, inf_o; sticky flags inv_sticky_o/inf_sticky_o cleared by
// sticky_clr_i when PFPU32_CMP_STICKY_EN is defined (tied 0 otherwise).
// OPTION_DAZ=1 flushes denormal operands to signed zero at unpack.
module pfpu32_cmp_ctrl
    import pfpu32_cmp_pkg::*;
#(
    parameter int OPTION_DAZ = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         start_i,
    output logic                         ready_o,
    input  logic [`OR1K_FPUOP_WIDTH-1:0] opc_i,
    input  logic                         unordered_i,
    input  logic [31:0]                  rfa_i,
    input  logic [31:0]                  rfb_i,
    output logic                         valid_o,
    input  logic                         ack_i,
    output logic                         flag_o,
    output logic                         inv_o,
    output logic                         inf_o,
    output logic                         inv_sticky_o,
    output logic                         inf_sticky_o,
    input  logic                         sticky_clr_i
);

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        cmp_done;
    logic [2:0]  cmp_sel;
    logic        unord;
    logic [31:0] a_raw;
    logic [31:0] b_raw;
    unpacked_t   ua;
    unpacked_t   ub;
    logic        flag;
    logic        inv;
    logic        inf;
    logic        valid;
    logic        cmp_flag;
    logic        cmp_inv;
    logic        cmp_inf;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        cmp_done  = 1'b0;
        ready_o   = 1'b0;
        unique case (state)
            S_IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    accept    = 1'b1;
                    state_nxt = S_UNPACK;
                end
            end
            S_UNPACK: state_nxt = S_CMP;
            S_CMP: begin
                cmp_done  = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                if (ack_i) begin
                    ready_o   = 1'b1;
                    accept    = start_i;
                    state_nxt = start_i ? S_UNPACK : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (rst || flush_i) begin
            ready_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            cmp_sel <= '0;
            unord   <= 1'b0;
            a_raw   <= '0;
            b_raw   <= '0;
            ua      <= '0;
            ub      <= '0;
            flag    <= 1'b0;
            inv     <= 1'b0;
            inf     <= 1'b0;
            valid   <= 1'b0;
        end else begin
            if (accept) begin
                cmp_sel <= opc_i[`OR1K_FPUOP_GENERIC_CMP_SELECT];
                unord   <= unordered_i;
                a_raw   <= rfa_i;
                b_raw   <= rfb_i;
            end
            if (state == S_UNPACK) begin
                ua <= unpack_op(a_raw, OPTION_DAZ != 0);
                ub <= unpack_op(b_raw, OPTION_DAZ != 0);
            end
            if (cmp_done) begin
                flag  <= cmp_flag;
                inv   <= cmp_inv;
                inf   <= cmp_inf;
                valid <= 1'b1;
            end else if (state == S_DONE && ack_i) begin
                valid <= 1'b0;
            end
        end
    end

    assign valid_o = valid;
    assign flag_o  = flag;
    assign inv_o   = inv;
    assign inf_o   = inf;

    pfpu32_fcmp u_fcmp (
        .fpu_op_is_comp_i (1'b1),
        .cmp_type_i       (cmp_sel),
        .unordered_i      (unord),
        .signa_i          (ua.sign),
        .exp10a_i         (ua.exp10),
        .fract24a_i       (ua.fract24),
        .snan_a_i         (ua.snan),
        .qnan_a_i         (ua.qnan),
        .inf_a_i          (ua.inf),
        .zero_a_i         (ua.zero),
        .signb_i          (ub.sign),
        .exp10b_i         (ub.exp10),
        .fract24b_i       (ub.fract24),
        .snan_b_i         (ub.snan),
        .qnan_b_i         (ub.qnan),
        .inf_b_i          (ub.inf),
        .zero_b_i         (ub.zero),
        .cmp_flag_o       (cmp_flag),
        .addsub_agtb_o    (),
        .addsub_aeqb_o    (),
        .inv_o            (cmp_inv),
        .inf_o            (cmp_inf)
    );

`ifdef PFPU32_CMP_STICKY_EN
    logic inv_sticky;
    logic inf_sticky;

    // A completing compare sets the bit even when a clear arrives
    // in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            inv_sticky <= 1'b0;
            inf_sticky <= 1'b0;
        end else begin
            inv_sticky <= (inv_sticky & ~sticky_clr_i) | (cmp_done & cmp_inv);
            inf_sticky <= (inf_sticky & ~sticky_clr_i) | (cmp_done & cmp_inf);
        end
    end

    assign inv_sticky_o = inv_sticky;
    assign inf_sticky_o = inf_sticky;
`else
    assign inv_sticky_o = 1'b0;
    assign inf_sticky_o = 1'b0;
`endif

endmodule

// File: tb/tb_pfpu32_cmp_ctrl.sv
// Directed self-checking bench for pfpu32_cmp_ctrl (DAZ off and DAZ on).
// Checks handshake timing, compare results, flush abort and sticky flags.
module tb_pfpu32_cmp_ctrl;

    localparam logic [7:0] SFEQ = 8'h08;
    localparam logic [7:0] SFNE = 8'h09;
    localparam logic [7:0] SFGT = 8'h0a;
    localparam logic [7:0] SFGE = 8'h0b;
    localparam logic [7:0] SFLT = 8'h0c;
    localparam logic [7:0] SFLE = 8'h0d;
    localparam logic [7:0] FREM = 8'h06;

    logic clk = 1'b0;
    logic rst, flush, start, unord, ack, sticky_clr;
    logic [`OR1K_FPUOP_WIDTH-1:0] opc;
    logic [31:0] rfa, rfb;
    logic ready, valid, flag, inv, inf, inv_st, inf_st;
    logic d_ready, d_valid, d_flag, d_inv, d_inf, d_inv_st, d_inf_st;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pfpu32_cmp_ctrl #(.OPTION_DAZ(0)) dut (
        .clk(clk), .rst(rst), .flush_i(flush), .start_i(start),
        .ready_o(ready), .opc_i(opc), .unordered_i(unord),
        .rfa_i(rfa), .rfb_i(rfb), .valid_o(valid), .ack_i(ack),
        .flag_o(flag), .inv_o(inv), .inf_o(inf),
        .inv_sticky_o(inv_st), .inf_sticky_o(inf_st),
        .sticky_clr_i(sticky_clr)
    );

    pfpu32_cmp_ctrl #(.OPTION_DAZ(1)) dut_daz (
        .clk(clk), .rst(rst), .flush_i(flush), .start_i(start),
        .ready_o(d_ready), .opc_i(opc), .unordered_i(unord),
        .rfa_i(rfa), .rfb_i(rfb), .valid_o(d_valid), .ack_i(ack),
        .flag_o(d_flag), .inv_o(d_inv), .inf_o(d_inf),
        .inv_sticky_o(d_inv_st), .inf_sticky_o(d_inf_st),
        .sticky_clr_i(sticky_clr)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [7:0] op, input logic u,
                         input logic [31:0] a, input logic [31:0] b);
        check("ready_idle", {31'd0, ready}, 1);
        opc   = op;
        unord = u;
        rfa   = a;
        rfb   = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("valid_t1", {31'd0, valid}, 0);
        @(posedge clk); #1;
        check("valid_t2", {31'd0, valid}, 0);
        @(posedge clk); #1;
        check("valid_t3", {31'd0, valid}, 1);
    endtask

    task automatic result(input string tag, input logic f,
                          input logic i, input logic n);
        check({tag, "_flag"}, {31'd0, flag}, {31'd0, f});
        check({tag, "_inv"}, {31'd0, inv}, {31'd0, i});
        check({tag, "_inf"}, {31'd0, inf}, {31'd0, n});
    endtask

    task automatic retire();
        ack = 1'b1;
        #1;
        check("ready_ack", {31'd0, ready}, 1);
        @(posedge clk); #1;
        ack = 1'b0;
        check("valid_drop", {31'd0, valid}, 0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; start = 1'b0; unord = 1'b0;
        ack = 1'b0; sticky_clr = 1'b0; opc = '0; rfa = '0; rfb = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, ready}, 0);
        check("rst_valid", {31'd0, valid}, 0);
        result("rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;

        issue(SFLT, 1'b0, 32'h3F800000, 32'h40000000);
        result("lt_1_2", 1'b1, 1'b0, 1'b0);
`ifdef PFPU32_CMP_STICKY_EN
        check("st_inv_clean", {31'd0, inv_st}, 0);
`endif
        retire();

        issue(SFEQ, 1'b0, 32'h7F800001, 32'h3F800000);
        result("snan_eq", 1'b0, 1'b1, 1'b0);
        retire();
`ifdef PFPU32_CMP_STICKY_EN
        check("st_inv_set", {31'd0, inv_st}, 1);
`endif

        issue(SFEQ, 1'b1, 32'h7F800001, 32'h3F800000);
        result("snan_ueq", 1'b1, 1'b1, 1'b0);
        retire();

        issue(SFLT, 1'b0, 32'h7FC00000, 32'h3F800000);
        result("qnan_lt", 1'b0, 1'b1, 1'b0);
        retire();

        issue(SFEQ, 1'b0, 32'h00000000, 32'h80000000);
        result("zero_eq", 1'b1, 1'b0, 1'b0);
        retire();

        issue(SFGT, 1'b0, 32'h00000001, 32'h00000000);
        result("denorm_gt", 1'b1, 1'b0, 1'b0);
        check("daz_gt_flag", {31'd0, d_flag}, 0);
        check("daz_valid", {31'd0, d_valid}, 1);
        retire();

        issue(SFGT, 1'b0, 32'h7F800000, 32'h7F7FFFFF);
        result("inf_gt", 1'b1, 1'b0, 1'b1);
        retire();
`ifdef PFPU32_CMP_STICKY_EN
        check("st_inf_set", {31'd0, inf_st}, 1);
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        check("st_inf_clr", {31'd0, inf_st}, 0);
        check("st_inv_clr", {31'd0, inv_st}, 0);
`else
        check("st_inv_tied", {31'd0, inv_st}, 0);
        check("st_inf_tied", {31'd0, inf_st}, 0);
`endif

        issue(SFLE, 1'b0, 32'hBF800000, 32'h3F800000);
        result("le_neg", 1'b1, 1'b0, 1'b0);
        retire();

        issue(SFLT, 1'b0, 32'hC0000000, 32'hBF800000);
        result("lt_negs", 1'b1, 1'b0, 1'b0);
        retire();

        issue(SFNE, 1'b0, 32'h40000000, 32'h3F800000);
        result("ne_2_1", 1'b1, 1'b0, 1'b0);
        retire();

        issue(SFGE, 1'b0, 32'h3F800000, 32'h3F800000);
        result("ge_eq", 1'b1, 1'b0, 1'b0);
        retire();

        issue(FREM, 1'b0, 32'h3F800000, 32'h3F800000);
        result("noncmp", 1'b0, 1'b0, 1'b0);
        retire();

        // flush while the compare is in flight
        opc = SFLT; unord = 1'b0;
        rfa = 32'h3F800000; rfb = 32'h40000000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        #1;
        check("flush_ready", {31'd0, ready}, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        check("flush_valid", {31'd0, valid}, 0);
        check("flush_idle", {31'd0, ready}, 1);
        @(posedge clk); #1;
        check("flush_valid2", {31'd0, valid}, 0);
        issue(SFLT, 1'b0, 32'h3F800000, 32'h40000000);
        result("post_flush", 1'b1, 1'b0, 1'b0);
        retire();

        // hold result, then back-to-back ack+start
        issue(SFGT, 1'b0, 32'h40000000, 32'h3F800000);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("hold_valid", {31'd0, valid}, 1);
            check("hold_flag", {31'd0, flag}, 1);
        end
        opc = SFGT; rfa = 32'h3F800000; rfb = 32'h40000000;
        start = 1'b1;
        ack   = 1'b1;
        #1;
        check("b2b_ready", {31'd0, ready}, 1);
        @(posedge clk); #1;
        start = 1'b0;
        ack   = 1'b0;
        check("b2b_drop1", {31'd0, valid}, 0);
        @(posedge clk); #1;
        check("b2b_drop2", {31'd0, valid}, 0);
        @(posedge clk); #1;
        check("b2b_valid", {31'd0, valid}, 1);
        result("b2b", 1'b0, 1'b0, 1'b0);
        retire();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pfpu32_cmp_ctrl.md
Name: pfpu32_cmp_ctrl

Overview:
Sequencing controller for the single-precision FP compare path. It accepts compare requests from the execute stage with a start/ready handshake and registers the raw IEEE-754 operands. It unpacks them into the exp10/fract24/class fields, drives the pfpu32_fcmp comparator, and returns a registered result held until the requester acknowledges. Flush and reset abort any in-flight compare.

Parameters:
OPTION_DAZ, 0, 1 = denormal operands treated as signed zero at unpack; 0 = denormals compared exactly.

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
flush_i  in  1  pipeline flush, synchronous abort
start_i  in  1  compare request valid
ready_o  out  1  request can be accepted this cycle
opc_i  in  `OR1K_FPUOP_WIDTH  full FPU compare opcode
unordered_i  in  1  unordered variant of the compare
rfa_i  in  32  operand a, raw IEEE-754
rfb_i  in  32  operand b, raw IEEE-754
valid_o  out  1  result valid
ack_i  in  1  result consumed
flag_o  out  1  compare flag
inv_o  out  1  invalid-operation exception
inf_o  out  1  infinity operand seen
inv_sticky_o  out  1  sticky invalid (optional feature)
inf_sticky_o  out  1  sticky infinity (optional feature)
sticky_clr_i  in  1  clear sticky bits (optional feature)

Behaviour:
- Reset/flush values: state = S_IDLE; valid_o, flag_o, inv_o, inf_o = 0; all operand and result registers = 0. rst and flush_i have equal priority and both override every other event in the same cycle.
- State S_IDLE:
  - ready_o = 1.
  - start_i at edge T0: register opc_i[`OR1K_FPUOP_GENERIC_CMP_SELECT], unordered_i, rfa_i, rfb_i; go to S_UNPACK.
- State S_UNPACK (cycle T1): register the unpacked fields, then go to S_CMP.
  - Sign = bit31.
  - exp10 = {2'b0, exp8}, with exp8 = 0 mapped to 1.
  - fract24 = {exp8 != 0, mant23}.
  - zero = exp8 == 0 and mant == 0; with OPTION_DAZ, zero = exp8 == 0.
  - inf = exp8 == 8'hFF and mant == 0.
  - qnan = exp8 == 8'hFF and mant[22].
  - snan = exp8 == 8'hFF and !mant[22] and mant != 0.
- State S_CMP (cycle T2):
  - pfpu32_fcmp is driven from registers with fpu_op_is_comp_i = 1.
  - At the edge, capture cmp_flag_o/inv_o/inf_o into flag_o/inv_o/inf_o, set valid_o = 1, go to S_DONE.
  - Latency: result visible 2 cycles after the acceptance edge.
- State S_DONE:
  - valid_o and results held stable while ack_i = 0.
  - ack_i without start_i: valid_o = 0, go to S_IDLE.
  - ack_i & start_i: clear valid_o, capture the new request, go to S_UNPACK (back-to-back).
- ready_o = (S_IDLE) | (S_DONE & ack_i). ready_o is combinational on ack_i and forced 0 while flush_i or rst is high.
- start_i in S_UNPACK or S_CMP is ignored; the requester must hold it until ready_o.
- addsub_agtb_o/addsub_aeqb_o from the comparator are left unconnected.
- No opcode check: a non-compare opcode produces flag_o = 0 via the comparator default.

Optional Feature:
Macro PFPU32_CMP_STICKY_EN.
- Defined: inv_sticky_o |= inv and inf_sticky_o |= inf on each S_CMP->S_DONE transition.
  - Cleared by sticky_clr_i, rst, or flush_i.
  - If sticky_clr_i coincides with a completion, set wins.
- Undefined: both sticky outputs tied to 0 and sticky_clr_i ignored.

Decomposition:
- Package pfpu32_cmp_pkg holds:
  - state enum (S_IDLE, S_UNPACK, S_CMP, S_DONE);
  - unpacked-operand struct (sign, exp10, fract24, snan, qnan, inf, zero);
  - constants EXP8_ALL1 = 8'hFF and QNAN_BIT = 22;
  - a unpack function used for both operands.
- One sub-module: the existing pfpu32_fcmp comparator, instantiated once.

Test Plan:
- a = 0x3F800000 (1.0), b = 0x40000000 (2.0), SFLT ordered, start at T0 -> valid_o at T2, flag_o = 1, inv_o = 0, inf_o = 0.
- a = 0x7F800001 (sNaN), b = 0x3F800000, SFEQ ordered -> flag_o = 0, inv_o = 1.
  - Same operands with unordered_i = 1 -> flag_o = 1, inv_o = 1.
  - a = 0x7FC00000 (qNaN), SFLT ordered -> inv_o = 1.
- a = 0x00000000 (+0), b = 0x80000000 (-0), SFEQ -> flag_o = 1.
  - a = 0x00000001, b = 0x00000000, SFGT -> flag_o = 1 with OPTION_DAZ = 0, flag_o = 0 with OPTION_DAZ = 1.
- a = 0x7F800000 (+inf), b = 0x7F7FFFFF, SFGT -> flag_o = 1, inf_o = 1.
  - With PFPU32_CMP_STICKY_EN: inf_sticky_o = 1 until sticky_clr_i.
- flush_i pulsed in S_CMP -> valid_o never asserts, state S_IDLE next cycle, ready_o = 1.
  - A new start is then accepted and completes normally 2 cycles later.
- Hold ack_i = 0 for 3 cycles in S_DONE -> valid_o and flag_o stable throughout.
  - Then ack_i & start_i in the same cycle -> ready_o = 1, valid_o drops for 2 cycles, second result appears exactly 2 cycles later.
